pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Instruction-fetch sequencer that owns the program counter and time-shares the single 32-bit PC adder between next-sequential-PC and branch-target computation. It sits between the instruction memory and the decode stage, issuing fetch requests, handing instructions to decode with a valid/ready handshake, and applying jump/branch redirects returned by decode.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- INC, 32'd4, sequential PC increment

- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- ADD_A  out  32  shared adder operand 1
- ADD_B  out  32  shared adder operand 2
- ADD_Y  in  32  shared adder result, combinational ADD_A+ADD_B, same cycle
- IM_REQ  out  1  instruction memory read request
- IM_ADDR  out  32  fetch address, equals PC
- IM_ACK  in  1  memory has data on IM_DATA this cycle
- IM_DATA  in  32  fetched instruction word
- INSTR  out  32  registered instruction to decode
- INSTR_VALID  out  1  INSTR holds an unconsumed instruction
- INSTR_READY  in  1  decode accepts INSTR this cycle
- JMP  in  1  jump for the accepted instruction
- JMP_TARGET  in  26  jump word index
- BR_TAKEN  in  1  taken branch for the accepted instruction
- BR_OFFSET  in  32  sign-extended word offset
- PC  out  32  current program counter

## Operation
- States: FETCH, ISSUE, BRANCH. Reset state FETCH.
- FETCH: IM_REQ=1, IM_ADDR=PC. On IM_ACK: INSTR<=IM_DATA, INSTR_VALID<=1, go ISSUE. No ack: stay.
- ISSUE: INSTR_VALID=1; ADD_A=PC, ADD_B=INC, so ADD_Y=PC+INC. Without INSTR_READY: stay, INSTR held. With INSTR_READY (handshake): INSTR_VALID<=0, PC4 register<=ADD_Y, then by priority:
  - JMP=1: PC<={ADD_Y[31:28], JMP_TARGET, 2'b00}, go FETCH.
  - else BR_TAKEN=1: latch BR_OFFSET, go BRANCH.
  - else PC<=ADD_Y, go FETCH.
- BRANCH: ADD_A=PC4, ADD_B={BR_OFFSET[29:0],2'b00}; PC<=ADD_Y; go FETCH.
- ADD_A/ADD_B=0 in FETCH.
- JMP and BR_TAKEN both high: jump wins, branch ignored.
- JMP, BR_TAKEN, BR_OFFSET, JMP_TARGET sampled only on the ISSUE handshake cycle; ignored otherwise.
- IM_ACK ignored outside FETCH; IM_DATA never written to INSTR outside FETCH.
- Arithmetic modulo 2^32: PC 32'hFFFF_FFFC + 4 -> 32'h0000_0000; negative offsets two's complement; offset bits [31:30] dropped by shift.
- Reset: PC<=RESET_PC, INSTR<=0, INSTR_VALID<=0, PC4<=0, state<=FETCH. Applies from any state; outstanding request abandoned; an IM_ACK coincident with RST discarded.

## Timing
- Reset values while RST high / cycle after: PC=RESET_PC, INSTR=0, INSTR_VALID=0, IM_REQ=0 during the RST cycle, IM_REQ=1 first cycle after RST deasserts.
- IM_REQ, IM_ADDR, ADD_A, ADD_B decoded from state/registers (combinational); INSTR, INSTR_VALID, PC registered.
- Ack in the request cycle: INSTR_VALID high next cycle.
- Sequential or jump: min 2 cycles/instruction (FETCH 1, ISSUE 1).
- Taken branch: min 3 cycles (FETCH, ISSUE, BRANCH); new IM_ADDR visible the cycle after BRANCH.
- PC updates on the clock edge ending the handshake (sequential/jump) or ending BRANCH.
- IM_REQ held continuously in FETCH until IM_ACK; IM_ADDR stable during that wait.

## Test plan
- Reset/sequential: RESET_PC=0, ack every request immediately -> IM_ADDR 0,4,8,12 on successive FETCH cycles, each 2 cycles apart; INSTR matches IM_DATA.
- Stall: hold INSTR_READY=0 5 cycles in ISSUE -> INSTR/INSTR_VALID/PC unchanged, IM_REQ=0 throughout; release -> next IM_ADDR=PC+4.
- Branch: at PC=32'h100, BR_TAKEN=1, BR_OFFSET=-2 -> BRANCH state, PC=32'h0FC; BR_OFFSET=3 -> PC=32'h110.
- Jump vs branch: PC=32'h1000_0040, JMP=1, BR_TAKEN=1, JMP_TARGET=26'h10 -> PC=32'h1000_0040, no BRANCH cycle.
- Wrap: RESET_PC=32'hFFFF_FFFC, one sequential instruction -> next IM_ADDR=32'h0000_0000.
- Reset mid-fetch: assert RST while IM_REQ waits with IM_ACK=1 in same cycle -> INSTR stays 0, INSTR_VALID=0, PC=RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: owns the PC and time-shares an external
// 32-bit adder between PC+4 and branch-target computation.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INC      = 32'd4
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] ADD_A,
    output logic [31:0] ADD_B,
    input  logic [31:0] ADD_Y,
    output logic        IM_REQ,
    output logic [31:0] IM_ADDR,
    input  logic        IM_ACK,
    input  logic [31:0] IM_DATA,
    output logic [31:0] INSTR,
    output logic        INSTR_VALID,
    input  logic        INSTR_READY,
    input  logic        JMP,
    input  logic [25:0] JMP_TARGET,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_OFFSET,
    output logic [31:0] PC
);

    typedef enum logic [1:0] {
        FETCH,
        ISSUE,
        BRANCH
    } state_t;

    state_t      state;
    logic [31:0] pc4;
    logic [31:0] br_off;

    // Request is masked during reset so an in-flight fetch is abandoned.
    assign IM_REQ  = (state == FETCH) && !RST;
    assign IM_ADDR = PC;

    always_comb begin
        ADD_A = 32'h0;
        ADD_B = 32'h0;
        unique case (state)
            ISSUE: begin
                ADD_A = PC;
                ADD_B = INC;
            end
            BRANCH: begin
                ADD_A = pc4;
                ADD_B = br_off << 2;
            end
            default: begin
                ADD_A = 32'h0;
                ADD_B = 32'h0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= FETCH;
            PC          <= RESET_PC;
            pc4         <= 32'h0;
            br_off      <= 32'h0;
            INSTR       <= 32'h0;
            INSTR_VALID <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (IM_ACK) begin
                        INSTR       <= IM_DATA;
                        INSTR_VALID <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (INSTR_READY) begin
                        INSTR_VALID <= 1'b0;
                        pc4         <= ADD_Y;
                        // Jump takes priority over a simultaneous branch.
                        if (JMP) begin
                            PC    <= {ADD_Y[31:28], JMP_TARGET, 2'b00};
                            state <= FETCH;
                        end else if (BR_TAKEN) begin
                            br_off <= BR_OFFSET;
                            state  <= BRANCH;
                        end else begin
                            PC    <= ADD_Y;
                            state <= FETCH;
                        end
                    end
                end
                BRANCH: begin
                    PC    <= ADD_Y;
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table of instructions plus
// hand-written reset-during-fetch and PC wrap sequences.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic [31:0] add_a0, add_b0, add_y0, im_addr0, im_data0, instr0, pc0;
    logic        im_req0, im_ack0, instr_valid0, ready0, jmp0, br0;
    logic [25:0] tgt0;
    logic [31:0] off0;

    logic [31:0] add_a1, add_b1, add_y1, im_addr1, im_data1, instr1, pc1;
    logic        im_req1, im_ack1, instr_valid1, ready1;

    assign add_y0 = add_a0 + add_b0;
    assign add_y1 = add_a1 + add_b1;

    pc_sequencer u0 (
        .CLK(clk), .RST(rst),
        .ADD_A(add_a0), .ADD_B(add_b0), .ADD_Y(add_y0),
        .IM_REQ(im_req0), .IM_ADDR(im_addr0),
        .IM_ACK(im_ack0), .IM_DATA(im_data0),
        .INSTR(instr0), .INSTR_VALID(instr_valid0),
        .INSTR_READY(ready0),
        .JMP(jmp0), .JMP_TARGET(tgt0),
        .BR_TAKEN(br0), .BR_OFFSET(off0),
        .PC(pc0)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u1 (
        .CLK(clk), .RST(rst),
        .ADD_A(add_a1), .ADD_B(add_b1), .ADD_Y(add_y1),
        .IM_REQ(im_req1), .IM_ADDR(im_addr1),
        .IM_ACK(im_ack1), .IM_DATA(im_data1),
        .INSTR(instr1), .INSTR_VALID(instr_valid1),
        .INSTR_READY(ready1),
        .JMP(1'b0), .JMP_TARGET(26'h0),
        .BR_TAKEN(1'b0), .BR_OFFSET(32'h0),
        .PC(pc1)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          ack_wait;
        int          stall;
        logic        jmp;
        logic        br;
        logic [25:0] tgt;
        logic [31:0] off;
        logic        exp_branch;
    } vec_t;

    vec_t vt[12];
    int   checks   = 0;
    int   failures = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        n = 0;
        while (!im_req0 && n < 20) begin
            step();
            n++;
        end
        check("fetch_req", {31'h0, im_req0}, 32'h1);
        check("fetch_addr", im_addr0, v.addr);
        check("fetch_pc", pc0, v.addr);
        check("fetch_adda", add_a0, 32'h0);
        for (int i = 0; i < v.ack_wait; i++) begin
            step();
            check("wait_req", {31'h0, im_req0}, 32'h1);
            check("wait_addr", im_addr0, v.addr);
        end
        im_ack0  = 1'b1;
        im_data0 = v.data;
        step();
        im_ack0  = 1'b0;
        im_data0 = 32'hBAD0_BAD0;
        check("issue_valid", {31'h0, instr_valid0}, 32'h1);
        check("issue_instr", instr0, v.data);
        check("issue_req", {31'h0, im_req0}, 32'h0);
        check("issue_adda", add_a0, v.addr);
        check("issue_addb", add_b0, 32'd4);
        for (int i = 0; i < v.stall; i++) begin
            im_ack0  = 1'b1;
            im_data0 = ~v.data;
            jmp0     = 1'b1;
            tgt0     = 26'h3FF_FFFF;
            step();
            check("stall_instr", instr0, v.data);
            check("stall_valid", {31'h0, instr_valid0}, 32'h1);
            check("stall_pc", pc0, v.addr);
            check("stall_req", {31'h0, im_req0}, 32'h0);
        end
        im_ack0 = 1'b0;
        ready0  = 1'b1;
        jmp0    = v.jmp;
        br0     = v.br;
        tgt0    = v.tgt;
        off0    = v.off;
        step();
        ready0 = 1'b0;
        jmp0   = 1'b0;
        br0    = 1'b1;
        tgt0   = 26'h155_5555;
        off0   = 32'h0000_0055;
        check("hs_valid", {31'h0, instr_valid0}, 32'h0);
        if (v.exp_branch) begin
            check("br_req", {31'h0, im_req0}, 32'h0);
            check("br_adda", add_a0, v.addr + 32'd4);
            check("br_addb", add_b0, v.off << 2);
            step();
        end
        br0 = 1'b0;
    endtask

    initial begin
        vt[0]  = '{32'h0000_0000, 32'h1111_0000, 0, 0, 0, 0, 26'h0, 32'h0, 0};
        vt[1]  = '{32'h0000_0004, 32'h1111_0004, 2, 0, 0, 0, 26'h0, 32'h0, 0};
        vt[2]  = '{32'h0000_0008, 32'h1111_0008, 0, 5, 0, 0, 26'h0, 32'h0, 0};
        vt[3]  = '{32'h0000_000C, 32'h2222_000C, 0, 0, 1, 0, 26'h40, 32'h0, 0};
        vt[4]  = '{32'h0000_0100, 32'h3333_0100, 0, 0, 0, 1, 26'h0,
                   32'hFFFF_FFFE, 1};
        vt[5]  = '{32'h0000_00FC, 32'h2222_00FC, 1, 0, 1, 0, 26'h40, 32'h0, 0};
        vt[6]  = '{32'h0000_0100, 32'h3333_0101, 0, 0, 0, 1, 26'h0, 32'd3, 1};
        vt[7]  = '{32'h0000_0110, 32'h2222_0110, 0, 0, 1, 0, 26'h10, 32'h0, 0};
        vt[8]  = '{32'h0000_0040, 32'h3333_0040, 0, 0, 0, 1, 26'h0,
                   32'h03FF_FFFF, 1};
        vt[9]  = '{32'h1000_0040, 32'h4444_0040, 0, 0, 1, 1, 26'h10,
                   32'd7, 0};
        vt[10] = '{32'h1000_0040, 32'h3333_0044, 0, 0, 0, 1, 26'h0,
                   32'hC000_0001, 1};
        vt[11] = '{32'h1000_0048, 32'h1111_0048, 0, 0, 0, 0, 26'h0, 32'h0, 0};

        rst = 1'b1;
        im_ack0 = 1'b0; im_data0 = 32'h0; ready0 = 1'b0;
        jmp0 = 1'b0; br0 = 1'b0; tgt0 = 26'h0; off0 = 32'h0;
        im_ack1 = 1'b0; im_data1 = 32'h0; ready1 = 1'b0;
        step();
        step();
        check("rst_pc", pc0, 32'h0);
        check("rst_instr", instr0, 32'h0);
        check("rst_valid", {31'h0, instr_valid0}, 32'h0);
        check("rst_req", {31'h0, im_req0}, 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_req", {31'h0, im_req0}, 32'h1);

        for (int i = 0; i < 12; i++) run_vec(vt[i]);
        check("final_addr", im_addr0, 32'h1000_004C);

        // Reset while a fetch waits, with an ack in the same cycle.
        step();
        rst      = 1'b1;
        im_ack0  = 1'b1;
        im_data0 = 32'hDEAD_BEEF;
        step();
        check("rstf_instr", instr0, 32'h0);
        check("rstf_valid", {31'h0, instr_valid0}, 32'h0);
        check("rstf_pc", pc0, 32'h0);
        check("rstf_req", {31'h0, im_req0}, 32'h0);
        rst     = 1'b0;
        im_ack0 = 1'b0;
        #1;
        check("rstf_req_after", {31'h0, im_req0}, 32'h1);
        check("rstf_addr_after", im_addr0, 32'h0);

        // Sequential wrap from the top of the address space.
        check("wrap_addr0", im_addr1, 32'hFFFF_FFFC);
        im_ack1  = 1'b1;
        im_data1 = 32'h5A5A_5A5A;
        step();
        im_ack1 = 1'b0;
        check("wrap_instr", instr1, 32'h5A5A_5A5A);
        ready1 = 1'b1;
        step();
        ready1 = 1'b0;
        check("wrap_addr1", im_addr1, 32'h0000_0000);
        check("wrap_req", {31'h0, im_req1}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
